inst_encoder: RTL and testbench

//  Packs field-level RISC-V instruction descriptions (opcode/funct/regs/imm + format)

---
 rtl/inst_encoder_if.sv | 33 +++
 rtl/inst_encoder.sv | 99 +++++++++
 tb/tb_inst_encoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Field-bundle input and IMEM write-port bundle for the RV32I instruction encoder.
// The master side is the program loader / memory; the slave side is the encoder.
interface inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1,
               in_rs2, in_imm, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1,
               in_rs2, in_imm, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_encoder.sv
// Packs RISC-V field bundles into RV32I words and streams them to IMEM through a
// single-entry, stallable write register.
module inst_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    inst_encoder_if.slave   bus,
    output logic            busy,
    output logic            done,
    output logic [ADDR_W:0] inst_count,
    output logic            err_fmt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic        last_q;
    logic [31:0] word;
    logic        fmt_bad;
    logic        accept;
    logic        wr_done;
    logic [31:0] imm;

    assign imm     = bus.in_imm;
    assign accept  = bus.in_valid && bus.in_ready;
    assign wr_done = bus.mem_we && bus.mem_ready;

    always_comb begin
        word    = 32'h0000_0013;
        fmt_bad = 1'b0;
        case (bus.in_fmt)
            3'd0: word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
            3'd1: word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            3'd2: word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0],
                          bus.in_opcode};
            3'd3: word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          imm[4:1], imm[11], bus.in_opcode};
            3'd4: word = {imm[31:12], bus.in_rd, bus.in_opcode};
            3'd5: word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd,
                          bus.in_opcode};
            default: fmt_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                // The output register can refill on the same edge it drains.
                bus.in_ready = !last_q && (!bus.mem_we || bus.mem_ready);
                if (wr_done && last_q) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= '0;
            inst_count    <= '0;
            err_fmt       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                inst_count   <= '0;
                err_fmt      <= 1'b0;
                last_q       <= 1'b0;
                bus.mem_addr <= BASE_ADDR;
            end
            if (wr_done) begin
                bus.mem_addr <= bus.mem_addr + 1'b1;
                if (inst_count != '1) inst_count <= inst_count + 1'b1;
            end
            if (accept) begin
                bus.mem_wdata <= word;
                last_q        <= bus.in_last;
                if (fmt_bad) err_fmt <= 1'b1;
            end
            if (accept) bus.mem_we <= 1'b1;
            else if (wr_done) bus.mem_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: table of encodings streamed back-to-back, then
// stall, start-in-RUN, async reset and address-wrap sequences.
module tb_inst_encoder;
    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       busy0, done0, err0, busy1, done1, err1;
    logic [10:0] cnt0;
    logic [2:0]  cnt1;
    int          pass = 0, total = 0;
    vec_t        tbl[10];

    inst_encoder_if #(.ADDR_W(10)) bus0 ();
    inst_encoder_if #(.ADDR_W(2))  bus1 ();

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(10'd0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .bus(bus0.slave),
        .busy(busy0), .done(done0), .inst_count(cnt0), .err_fmt(err0)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(2'd3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bus(bus1.slave),
        .busy(busy1), .done(done1), .inst_count(cnt1), .err_fmt(err1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                input logic [31:0] exp);
        vec_t v;
        v.fmt = fmt; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic put0(input vec_t v, input logic last);
        bus0.in_fmt = v.fmt; bus0.in_opcode = v.op; bus0.in_funct3 = v.f3;
        bus0.in_funct7 = v.f7; bus0.in_rd = v.rd; bus0.in_rs1 = v.rs1;
        bus0.in_rs2 = v.rs2; bus0.in_imm = v.imm; bus0.in_last = last;
        bus0.in_valid = 1'b1;
    endtask

    task automatic put1(input vec_t v, input logic last);
        bus1.in_fmt = v.fmt; bus1.in_opcode = v.op; bus1.in_funct3 = v.f3;
        bus1.in_funct7 = v.f7; bus1.in_rd = v.rd; bus1.in_rs1 = v.rs1;
        bus1.in_rs2 = v.rs2; bus1.in_imm = v.imm; bus1.in_last = last;
        bus1.in_valid = 1'b1;
    endtask

    initial begin
        //           fmt   op     f3    f7     rd     rs1    rs2    imm            expected
        tbl[0] = mk(3'd0, 7'h33, 3'd0, 7'h00, 5'd3,  5'd1,  5'd2,  32'h0,         32'h002081B3);
        tbl[1] = mk(3'd0, 7'h33, 3'd0, 7'h20, 5'd5,  5'd6,  5'd7,  32'h0,         32'h407302B3);
        tbl[2] = mk(3'd1, 7'h13, 3'd0, 7'h7F, 5'd1,  5'd0,  5'd31, 32'd5,         32'h00500093);
        tbl[3] = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd1,  5'd1,  5'd0,  32'hFFFFFFFF,  32'hFFF08093);
        tbl[4] = mk(3'd2, 7'h23, 3'd2, 7'h00, 5'd0,  5'd1,  5'd2,  32'd8,         32'h0020A423);
        tbl[5] = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,  32'hFE208EE3);
        tbl[6] = mk(3'd4, 7'h37, 3'd7, 7'h7F, 5'd5,  5'd31, 5'd31, 32'h12345000,  32'h123452B7);
        tbl[7] = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0,  32'h00000800,  32'h001000EF);
        tbl[8] = mk(3'd7, 7'h33, 3'd5, 7'h55, 5'd9,  5'd9,  5'd9,  32'h12345678,  32'h00000013);
        tbl[9] = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0000006F);

        bus0.in_valid = 0; bus0.in_last = 0; bus0.mem_ready = 1;
        bus1.in_valid = 0; bus1.in_last = 0; bus1.mem_ready = 1;
        put0(tbl[0], 1'b0); bus0.in_valid = 0;
        put1(tbl[0], 1'b0); bus1.in_valid = 0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus0.in_ready, 0);
        chk("rst_mem_we", bus0.mem_we, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_addr", bus0.mem_addr, 0);
        chk("rst_wdata", bus0.mem_wdata, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_addr_base3", bus1.mem_addr, 3);

        // Session 1: whole table back-to-back at one word per cycle.
        rst = 0;
        @(negedge clk) start0 = 1;
        @(negedge clk) start0 = 0;
        chk("s1_busy", busy0, 1);
        for (int i = 0; i < 10; i++) begin
            put0(tbl[i], i == 9);
            #1 chk($sformatf("v%0d_in_ready", i), bus0.in_ready, 1);
            @(negedge clk);
            chk($sformatf("v%0d_mem_we", i), bus0.mem_we, 1);
            chk($sformatf("v%0d_wdata", i), bus0.mem_wdata, tbl[i].exp);
            chk($sformatf("v%0d_addr", i), bus0.mem_addr, i);
            if (i == 9) chk("after_last_in_ready", bus0.in_ready, 0);
        end
        bus0.in_valid = 0;
        @(negedge clk);
        chk("s1_done", done0, 1);
        chk("s1_busy_done", busy0, 0);
        chk("s1_count", cnt0, 10);
        chk("s1_err", err0, 1);
        @(negedge clk);
        chk("s1_done_pulse", done0, 0);
        chk("s1_err_sticky", err0, 1);

        // Session 2: stalled write, start while running, then drain.
        start0 = 1;
        @(negedge clk) start0 = 0;
        chk("s2_err_clr", err0, 0);
        chk("s2_count_clr", cnt0, 0);
        bus0.mem_ready = 0;
        put0(tbl[2], 1'b0);
        @(negedge clk);
        put0(tbl[4], 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", k), bus0.in_ready, 0);
            chk($sformatf("stall%0d_mem_we", k), bus0.mem_we, 1);
            chk($sformatf("stall%0d_wdata", k), bus0.mem_wdata, 32'h00500093);
            chk($sformatf("stall%0d_addr", k), bus0.mem_addr, 0);
            start0 = (k == 1);
            @(negedge clk);
        end
        start0 = 0;
        bus0.mem_ready = 1;
        #1 chk("drain_in_ready", bus0.in_ready, 1);
        @(negedge clk);
        bus0.in_valid = 0;
        chk("s2_wdata_sw", bus0.mem_wdata, 32'h0020A423);
        chk("s2_addr_sw", bus0.mem_addr, 1);
        chk("s2_count1", cnt0, 1);
        chk("s2_busy", busy0, 1);
        @(negedge clk);
        chk("s2_done", done0, 1);
        chk("s2_count2", cnt0, 2);
        @(negedge clk);

        // Session 3: async reset with a write pending.
        start0 = 1;
        @(negedge clk) start0 = 0;
        bus0.mem_ready = 0;
        put0(tbl[0], 1'b0);
        @(negedge clk);
        bus0.in_valid = 0;
        chk("s3_pending", bus0.mem_we, 1);
        rst = 1;
        #1;
        chk("s3_rst_mem_we", bus0.mem_we, 0);
        chk("s3_rst_busy", busy0, 0);
        chk("s3_rst_addr", bus0.mem_addr, 0);
        chk("s3_rst_wdata", bus0.mem_wdata, 0);
        chk("s3_rst_count", cnt0, 0);
        chk("s3_rst_in_ready", bus0.in_ready, 0);
        @(negedge clk) rst = 0;
        bus0.mem_ready = 1;
        @(negedge clk);
        chk("s3_dropped", bus0.mem_we, 0);
        chk("s3_idle", busy0, 0);

        // Narrow IMEM starting at the top word: address wraps to 0.
        start1 = 1;
        @(negedge clk) start1 = 0;
        put1(tbl[0], 1'b0);
        @(negedge clk);
        chk("w_addr0", bus1.mem_addr, 3);
        chk("w_wdata0", bus1.mem_wdata, 32'h002081B3);
        put1(tbl[9], 1'b1);
        @(negedge clk);
        bus1.in_valid = 0;
        chk("w_addr1", bus1.mem_addr, 0);
        chk("w_wdata1", bus1.mem_wdata, 32'h0000006F);
        @(negedge clk);
        chk("w_done", done1, 1);
        chk("w_count", cnt1, 2);
        chk("w_addr_end", bus1.mem_addr, 1);
        chk("w_err", err1, 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
